// File: rtl/weight_addrgen_multiport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_addrgen_multiport_pkg
//  Description : Shared defaults and FSM state encoding for the multi-port
//                weight-ROM address generator.
//  Contents    : default geometry widths, state_t enumeration
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_addrgen_multiport_pkg;

    localparam int unsigned c_DEF_NUM_PORTS = 2;
    localparam int unsigned c_DEF_ADDR_W    = 16;
    localparam int unsigned c_DEF_BEAT_W    = 10;
    localparam int unsigned c_DEF_PIX_W     = 12;
    localparam int unsigned c_DEF_GRP_W     = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/weight_addrgen_multiport_if.sv
`default_nettype none
// ============================================================================
//  Module      : weight_addrgen_multiport_if
//  Description : Control/config/address bundle between the layer controller
//                (master) and the weight address generator (slave).
//  Signals     : start, abort, enable, cfg_base, cfg_beats_m1, cfg_outpix_m1,
//                cfg_groups_m1 (master -> slave)
//                addr, addr_valid, busy, done (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface weight_addrgen_multiport_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int BEAT_W    = 10,
    parameter int PIX_W     = 12,
    parameter int GRP_W     = 6
);
    logic                        start;
    logic                        abort;
    logic                        enable;
    logic [ADDR_W-1:0]           cfg_base;
    logic [BEAT_W-1:0]           cfg_beats_m1;
    logic [PIX_W-1:0]            cfg_outpix_m1;
    logic [GRP_W-1:0]            cfg_groups_m1;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic                        addr_valid;
    logic                        busy;
    logic                        done;

    modport master (
        output start, abort, enable,
        output cfg_base, cfg_beats_m1, cfg_outpix_m1, cfg_groups_m1,
        input  addr, addr_valid, busy, done
    );

    modport slave (
        input  start, abort, enable,
        input  cfg_base, cfg_beats_m1, cfg_outpix_m1, cfg_groups_m1,
        output addr, addr_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/weight_addrgen_multiport_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : weight_wrap_counter
//  Description : Wrapping counter 0..max. clr has priority over inc; on inc
//                at max the count returns to 0.
//  Ports       : clk, reset (async active-low), inc, clr, max -> cnt, last
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_wrap_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             inc,
    input  wire logic             clr,
    input  wire logic [WIDTH-1:0] max,
    output logic      [WIDTH-1:0] cnt,
    output logic                  last
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= last ? '0 : r_cnt + WIDTH'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == max);
endmodule
`default_nettype wire

// File: rtl/weight_addrgen_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : weight_addrgen_multiport
//  Description : Weight-ROM address generator driving NUM_PORTS read lanes.
//                Lane k address = grp_base + beat*NUM_PORTS + k, nested
//                beat / pixel / group loops, start/busy/done handshake.
//  Ports       : clk, reset (async active-low), bus (slave modport of
//                weight_addrgen_multiport_if)
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_addrgen_multiport
    import weight_addrgen_multiport_pkg::*;
#(
    parameter int NUM_PORTS = c_DEF_NUM_PORTS,
    parameter int ADDR_W    = c_DEF_ADDR_W,
    parameter int BEAT_W    = c_DEF_BEAT_W,
    parameter int PIX_W     = c_DEF_PIX_W,
    parameter int GRP_W     = c_DEF_GRP_W
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    weight_addrgen_multiport_if.slave  bus
);
    localparam logic [ADDR_W-1:0] c_LANE_STEP = ADDR_W'(NUM_PORTS);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [BEAT_W-1:0]           r_beats_m1;
    logic [PIX_W-1:0]            r_outpix_m1;
    logic [GRP_W-1:0]            r_groups_m1;
    logic [ADDR_W-1:0]           r_grp_base;
    logic [ADDR_W-1:0]           r_beat_off;   // tracks beat*NUM_PORTS incrementally
    logic [NUM_PORTS*ADDR_W-1:0] r_addr;
    logic                        r_addr_valid;
    logic                        r_done;
    logic [NUM_PORTS*ADDR_W-1:0] w_lane_addr;

    logic              w_accept;
    logic              w_issue;
    logic              w_pix_inc;
    logic              w_grp_inc;
    logic              w_final;
    logic              w_beat_last;
    logic              w_pix_last;
    logic              w_grp_last;
    logic [BEAT_W-1:0] w_beat_cnt;
    logic [PIX_W-1:0]  w_pix_cnt;
    logic [GRP_W-1:0]  w_grp_cnt;
    logic              w_unused_cnt;

    // abort outranks both start and enable
    assign w_accept  = (r_state == ST_IDLE) & bus.start  & ~bus.abort;
    assign w_issue   = (r_state == ST_RUN)  & bus.enable & ~bus.abort;
    assign w_pix_inc = w_issue   & w_beat_last;
    assign w_grp_inc = w_pix_inc & w_pix_last;
    assign w_final   = w_grp_inc & w_grp_last;

    weight_wrap_counter #(.WIDTH(BEAT_W)) u_beat_cnt (
        .clk(clk), .reset(reset), .inc(w_issue), .clr(w_accept),
        .max(r_beats_m1), .cnt(w_beat_cnt), .last(w_beat_last)
    );

    weight_wrap_counter #(.WIDTH(PIX_W)) u_pix_cnt (
        .clk(clk), .reset(reset), .inc(w_pix_inc), .clr(w_accept),
        .max(r_outpix_m1), .cnt(w_pix_cnt), .last(w_pix_last)
    );

    weight_wrap_counter #(.WIDTH(GRP_W)) u_grp_cnt (
        .clk(clk), .reset(reset), .inc(w_grp_inc), .clr(w_accept),
        .max(r_groups_m1), .cnt(w_grp_cnt), .last(w_grp_last)
    );

    // Only the wrap flags steer the datapath; counts are kept for visibility.
    assign w_unused_cnt = ^{w_beat_cnt, w_pix_cnt, w_grp_cnt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (bus.abort || w_final) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    generate
        for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
            assign w_lane_addr[k*ADDR_W +: ADDR_W] = r_grp_base + r_beat_off + ADDR_W'(k);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beats_m1   <= '0;
            r_outpix_m1  <= '0;
            r_groups_m1  <= '0;
            r_grp_base   <= '0;
            r_beat_off   <= '0;
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_addr_valid <= w_issue;
            r_done       <= w_final;
            if (w_accept) begin
                r_beats_m1  <= bus.cfg_beats_m1;
                r_outpix_m1 <= bus.cfg_outpix_m1;
                r_groups_m1 <= bus.cfg_groups_m1;
                r_grp_base  <= bus.cfg_base;
                r_beat_off  <= '0;
            end
            if (w_issue) begin
                r_addr <= w_lane_addr;
                if (w_beat_last) begin
                    r_beat_off <= '0;
                    // On the last beat r_beat_off = beats_m1*NUM_PORTS, so one more
                    // step gives the group stride without a multiplier.
                    if (w_grp_inc && !w_grp_last) begin
                        r_grp_base <= r_grp_base + r_beat_off + c_LANE_STEP;
                    end
                end else begin
                    r_beat_off <= r_beat_off + c_LANE_STEP;
                end
            end
        end
    end

    assign bus.addr       = r_addr;
    assign bus.addr_valid = r_addr_valid;
    assign bus.busy       = (r_state == ST_RUN);
    assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_weight_addrgen_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_addrgen_multiport
//  Description : Scoreboard bench for weight_addrgen_multiport. Two DUTs:
//                dut_a with 2 lanes, dut_b with 4 lanes. Expected beats are
//                queued by the stimulus; negedge monitors pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_addrgen_multiport;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    weight_addrgen_multiport_if #(.NUM_PORTS(2), .ADDR_W(16), .BEAT_W(10), .PIX_W(12), .GRP_W(6)) bus_a ();
    weight_addrgen_multiport_if #(.NUM_PORTS(4), .ADDR_W(16), .BEAT_W(10), .PIX_W(12), .GRP_W(6)) bus_b ();

    weight_addrgen_multiport #(.NUM_PORTS(2), .ADDR_W(16), .BEAT_W(10), .PIX_W(12), .GRP_W(6)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    weight_addrgen_multiport #(.NUM_PORTS(4), .ADDR_W(16), .BEAT_W(10), .PIX_W(12), .GRP_W(6)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct {
        logic [63:0] addr;
        bit          done;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: straightforward triple loop, first 'limit' beats only.
    function automatic void push_seq(input bit to_b, input int np, input logic [15:0] base,
                                     input int b, input int p, input int g, input int limit);
        int n = 0;
        for (int gi = 0; gi <= g; gi++)
            for (int pi = 0; pi <= p; pi++)
                for (int bi = 0; bi <= b; bi++) begin
                    if (n < limit) begin
                        exp_t e;
                        e.addr = '0;
                        for (int k = 0; k < np; k++)
                            e.addr[k*16 +: 16] = base + 16'(gi*(b+1)*np + bi*np + k);
                        e.done = (gi == g) && (pi == p) && (bi == b);
                        if (to_b) q_b.push_back(e);
                        else      q_a.push_back(e);
                    end
                    n++;
                end
    endfunction

    always @(negedge clk) begin
        if (reset && bus_a.addr_valid) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_a_unexpected: got addr %h, expected no beat", bus_a.addr);
            end else begin
                e_a = q_a.pop_front();
                check("mon_a_addr", {32'b0, bus_a.addr}, e_a.addr);
                check("mon_a_done", {63'b0, bus_a.done}, {63'b0, e_a.done});
            end
        end else if (reset) begin
            check("mon_a_stray_done", {63'b0, bus_a.done}, 64'd0);
        end
    end

    always @(negedge clk) begin
        if (reset && bus_b.addr_valid) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_b_unexpected: got addr %h, expected no beat", bus_b.addr);
            end else begin
                e_b = q_b.pop_front();
                check("mon_b_addr", bus_b.addr, e_b.addr);
                check("mon_b_done", {63'b0, bus_b.done}, {63'b0, e_b.done});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [15:0] base, input int b, input int p, input int g);
        bus_a.cfg_base      = base;
        bus_a.cfg_beats_m1  = 10'(b);
        bus_a.cfg_outpix_m1 = 12'(p);
        bus_a.cfg_groups_m1 = 6'(g);
        bus_a.start         = 1'b1;
        tick();
        bus_a.start         = 1'b0;
        check("start_a_busy", {63'b0, bus_a.busy}, 64'd1);
    endtask

    // Drives enable until 'total' beats are issued; optional mid-run start
    // pulse and abort at a given beat index (-1 disables either).
    task automatic run_a(input string tag, input int total, input bit toggle,
                         input int mid_start_at, input int abort_at,
                         input bit busy_end, output int cycles);
        int issued = 0;
        int cyc    = 0;
        bit en;
        while (issued < total && cyc < 400) begin
            en = toggle ? (cyc % 2 == 0) : 1'b1;
            bus_a.enable = en;
            if (en && issued == abort_at) bus_a.abort = 1'b1;
            if (cyc == mid_start_at) begin
                bus_a.start         = 1'b1;
                bus_a.cfg_base      = 16'h1234;
                bus_a.cfg_beats_m1  = 10'd0;
                bus_a.cfg_outpix_m1 = 12'd0;
                bus_a.cfg_groups_m1 = 6'd0;
            end
            tick();
            check({tag, "_valid"}, {63'b0, bus_a.addr_valid}, {63'b0, (en && !bus_a.abort)});
            bus_a.start = 1'b0;
            if (bus_a.abort) begin
                bus_a.abort  = 1'b0;
                bus_a.enable = 1'b0;
                check({tag, "_busy_after_abort"}, {63'b0, bus_a.busy}, 64'd0);
                cycles = cyc + 1;
                return;
            end
            if (en) issued++;
            cyc++;
        end
        bus_a.enable = 1'b0;
        cycles = cyc;
        if (issued < total) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: issued %0d beats, required %0d", tag, issued, total);
        end
        check({tag, "_busy_end"}, {63'b0, bus_a.busy}, {63'b0, busy_end});
    endtask

    task automatic drain(input string tag);
        tick();
        tick();
        check({tag, "_q_a_drained"}, 64'(q_a.size()), 64'd0);
        check({tag, "_q_b_drained"}, 64'(q_b.size()), 64'd0);
        check({tag, "_done_low"}, {63'b0, bus_a.done}, 64'd0);
    endtask

    task automatic single_b(input logic [15:0] base, input string tag);
        push_seq(1'b1, 4, base, 0, 0, 0, 1);
        bus_b.cfg_base      = base;
        bus_b.cfg_beats_m1  = 10'd0;
        bus_b.cfg_outpix_m1 = 12'd0;
        bus_b.cfg_groups_m1 = 6'd0;
        bus_b.start         = 1'b1;
        tick();
        bus_b.start  = 1'b0;
        bus_b.enable = 1'b1;
        tick();
        bus_b.enable = 1'b0;
        check({tag, "_valid"}, {63'b0, bus_b.addr_valid}, 64'd1);
        check({tag, "_done"},  {63'b0, bus_b.done}, 64'd1);
        check({tag, "_busy"},  {63'b0, bus_b.busy}, 64'd0);
        tick();
        check({tag, "_done_clear"}, {63'b0, bus_b.done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        {bus_a.start, bus_a.abort, bus_a.enable} = 3'b000;
        {bus_b.start, bus_b.abort, bus_b.enable} = 3'b000;
        bus_a.cfg_base = '0; bus_a.cfg_beats_m1 = '0; bus_a.cfg_outpix_m1 = '0; bus_a.cfg_groups_m1 = '0;
        bus_b.cfg_base = '0; bus_b.cfg_beats_m1 = '0; bus_b.cfg_outpix_m1 = '0; bus_b.cfg_groups_m1 = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_addr",  {32'b0, bus_a.addr}, 64'd0);
        check("rst_valid", {63'b0, bus_a.addr_valid}, 64'd0);
        check("rst_busy",  {63'b0, bus_a.busy}, 64'd0);
        check("rst_done",  {63'b0, bus_a.done}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // start and abort together in IDLE: stays idle
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        check("start_abort_idle_busy", {63'b0, bus_a.busy}, 64'd0);

        // 1: full nested run, continuous enable
        push_seq(1'b0, 2, 16'h0000, 2, 1, 1, 12);
        start_a(16'h0000, 2, 1, 1);
        run_a("t1", 12, 1'b0, -1, -1, 1'b0, cyc);
        check("t1_cycles", 64'(cyc), 64'd12);
        drain("t1");

        // 2: enable toggling 1,0
        push_seq(1'b0, 2, 16'h0000, 2, 1, 1, 12);
        start_a(16'h0000, 2, 1, 1);
        run_a("t2", 12, 1'b1, -1, -1, 1'b0, cyc);
        check("t2_cycles", 64'(cyc), 64'd23);
        drain("t2");

        // 3: 4 lanes, single beat, then wrap across 2^16
        single_b(16'hFFFC, "t3a");
        single_b(16'hFFFE, "t3b");
        drain("t3");

        // 4: abort on the 5th beat, then a clean replay
        push_seq(1'b0, 2, 16'h0000, 2, 1, 1, 4);
        start_a(16'h0000, 2, 1, 1);
        run_a("t4", 12, 1'b0, -1, 4, 1'b0, cyc);
        drain("t4_abort");
        push_seq(1'b0, 2, 16'h0000, 2, 1, 1, 12);
        start_a(16'h0000, 2, 1, 1);
        run_a("t4r", 12, 1'b0, -1, -1, 1'b0, cyc);
        drain("t4r");

        // 5: start with different cfg mid-run is ignored
        push_seq(1'b0, 2, 16'h0100, 2, 1, 1, 12);
        start_a(16'h0100, 2, 1, 1);
        run_a("t5", 12, 1'b0, 5, -1, 1'b0, cyc);
        drain("t5");

        // 6: async reset during the 7th beat, then a clean full run
        push_seq(1'b0, 2, 16'h0040, 2, 1, 1, 6);
        start_a(16'h0040, 2, 1, 1);
        run_a("t6", 6, 1'b0, -1, -1, 1'b1, cyc);
        bus_a.enable = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("t6_rst_addr",  {32'b0, bus_a.addr}, 64'd0);
        check("t6_rst_valid", {63'b0, bus_a.addr_valid}, 64'd0);
        check("t6_rst_busy",  {63'b0, bus_a.busy}, 64'd0);
        check("t6_rst_done",  {63'b0, bus_a.done}, 64'd0);
        bus_a.enable = 1'b0;
        tick();
        tick();
        check("t6_rst_hold_done", {63'b0, bus_a.done}, 64'd0);
        reset = 1'b1;
        tick();
        check("t6_q_after_reset", 64'(q_a.size()), 64'd0);
        push_seq(1'b0, 2, 16'h0040, 2, 1, 1, 12);
        start_a(16'h0040, 2, 1, 1);
        run_a("t6r", 12, 1'b0, -1, -1, 1'b0, cyc);
        drain("t6r");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
